// File: rtl/bcd_multi_counter_disp.sv
// rtl/bcd_multi_counter_disp.sv - DIGITS-decade BCD up/down counter with multiplexed 7-segment scan
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading-zero digits, digit 0 always shown).
module bcd_multi_counter_disp #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  CK,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Up_Dow,
    input  logic                  Cr,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] r_count;
    logic                r_carry;
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_sel;

    logic [4*DIGITS-1:0] w_next;
    logic                w_wrap;
    logic                w_low9;
    logic                w_low0;
    logic [3:0]          w_dig;
    logic [3:0]          w_cur;
    logic                w_zero_above;
    logic                w_blank;
    logic [DIGITS-1:0]   w_sel;
    logic [6:0]          w_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b0111111;
            4'd1:    f_decode = 7'b0000110;
            4'd2:    f_decode = 7'b1011011;
            4'd3:    f_decode = 7'b1001111;
            4'd4:    f_decode = 7'b1100110;
            4'd5:    f_decode = 7'b1101101;
            4'd6:    f_decode = 7'b1111101;
            4'd7:    f_decode = 7'b0000111;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1101111;
            default: f_decode = 7'b0000000;
        endcase
    endfunction

    // Ripple the "all lower digits at limit" condition up through the decades.
    always_comb begin
        w_next = r_count;
        w_low9 = 1'b1;
        w_low0 = 1'b1;
        w_dig  = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_dig = r_count[4*k +: 4];
            if (Up_Dow) begin
                if (w_low9)
                    w_next[4*k +: 4] = (w_dig >= 4'd9) ? 4'd0 : w_dig + 4'd1;
            end else begin
                if (w_low0)
                    w_next[4*k +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
            end
            w_low9 = w_low9 & (w_dig == 4'd9);
            w_low0 = w_low0 & (w_dig == 4'd0);
        end
        w_wrap = Up_Dow ? w_low9 : w_low0;
    end

    // Select the scanned digit and decide whether it is a leading zero.
    always_comb begin
        w_cur        = 4'd0;
        w_blank      = 1'b0;
        w_zero_above = 1'b1;
        w_sel        = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_above = w_zero_above & (r_count[4*k +: 4] == 4'd0);
            if (r_idx == IW'(k)) begin
                w_cur   = r_count[4*k +: 4];
                w_blank = w_zero_above && (k != 0);
            end
            w_sel[k] = (r_idx == IW'(k));
        end
`ifdef LEADING_ZERO_BLANK_EN
        w_seg = w_blank ? 7'b0000000 : f_decode(w_cur);
`else
        w_seg = f_decode(w_cur);
`endif
    end

    always_ff @(posedge CK or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
            r_carry <= 1'b0;
            r_pre   <= '0;
            r_idx   <= '0;
            r_sel   <= DIGITS'(1);
            r_seg   <= 7'b0111111;
        end else begin
            r_carry <= 1'b0;
            if (Cr) begin
                r_count <= '0;
            end else if (Load) begin
                for (int k = 0; k < DIGITS; k++)
                    r_count[4*k +: 4] <= (load_value[4*k +: 4] > 4'd9) ? 4'd9 : load_value[4*k +: 4];
            end else if (Enable) begin
                r_count <= w_next;
                r_carry <= w_wrap;
            end

            if (r_pre == PW'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end else begin
                r_pre <= r_pre + PW'(1);
            end

            r_sel <= w_sel;
            r_seg <= w_seg;
        end
    end

    assign count     = r_count;
    assign carry_out = r_carry;
    assign seg       = r_seg;
    assign digit_sel = r_sel;

endmodule

// File: tb/tb_bcd_multi_counter_disp.sv
// tb/tb_bcd_multi_counter_disp.sv - scoreboard bench for bcd_multi_counter_disp (DIGITS=2, SCAN_DIV=4)
module tb_bcd_multi_counter_disp;

    localparam int D  = 2;
    localparam int SD = 4;

    logic       CK = 1'b0;
    logic       Reset = 1'b0;
    logic       Enable = 1'b0;
    logic       Up_Dow = 1'b0;
    logic       Cr = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] count;
    logic       carry_out;
    logic [6:0] seg;
    logic [1:0] digit_sel;

    bcd_multi_counter_disp #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .CK(CK), .Reset(Reset), .Enable(Enable), .Up_Dow(Up_Dow), .Cr(Cr),
        .Load(Load), .load_value(load_value), .count(count), .carry_out(carry_out),
        .seg(seg), .digit_sel(digit_sel)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [7:0] cnt;
        logic       c;
        logic [6:0] sg;
        logic [1:0] sel;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m = 0;
    int   m_pre = 0;
    int   m_idx = 0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic cycle(input string tag, input logic en, input logic up, input logic cr,
                         input logic ld, input logic [7:0] lv);
        exp_t e;
        int   t;
        int   o;
        int   dg;
        Enable = en; Up_Dow = up; Cr = cr; Load = ld; load_value = lv;
        e.sel = (m_idx == 0) ? 2'b01 : 2'b10;
        dg    = (m_idx == 0) ? (m % 10) : (m / 10);
        e.sg  = seg_tab[dg];
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx == 1 && m / 10 == 0) e.sg = 7'b0000000;
`endif
        if (m_pre == SD - 1) begin
            m_pre = 0;
            m_idx = (m_idx + 1) % D;
        end else begin
            m_pre++;
        end
        e.c = 1'b0;
        if (cr) begin
            m = 0;
        end else if (ld) begin
            t = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
            o = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
            m = t * 10 + o;
        end else if (en) begin
            if (up) begin
                e.c = (m == 99);
                m   = (m + 1) % 100;
            end else begin
                e.c = (m == 0);
                m   = (m == 0) ? 99 : m - 1;
            end
        end
        e.cnt = bcd(m);
        q.push_back(e);
        @(posedge CK);
        #1;
        checks++;
        assert (q.size() > 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty observed 0 expected 1", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_count"}, 32'(count), 32'(e.cnt));
            chk({tag, "_carry"}, 32'(carry_out), 32'(e.c));
            chk({tag, "_seg"}, 32'(seg), 32'(e.sg));
            chk({tag, "_sel"}, 32'(digit_sel), 32'(e.sel));
        end
    endtask

    initial begin
        repeat (2) @(posedge CK);
        #1;
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_carry", 32'(carry_out), 32'h0);
        chk("rst_sel", 32'(digit_sel), 32'h1);
        chk("rst_seg", 32'(seg), 32'h3F);
        Reset = 1'b1;

        for (int i = 0; i < 100; i++) cycle("up", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        cycle("down_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle("down_98", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        cycle("load_3F", 1'b0, 1'b1, 1'b0, 1'b1, 8'h3F);
        cycle("load_cr", 1'b1, 1'b1, 1'b1, 1'b1, 8'h3F);
        cycle("load_A5", 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 6; i++) cycle("up_95", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle("cr_en", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle("down_00", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        cycle("load_27", 1'b0, 1'b1, 1'b0, 1'b1, 8'h27);
        for (int i = 0; i < 12; i++) cycle("scan_27", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cycle("hold_en0", 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);

        cycle("load_56", 1'b0, 1'b1, 1'b0, 1'b1, 8'h56);
        cycle("up_57", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'h00);
        chk("async_carry", 32'(carry_out), 32'h0);
        chk("async_sel", 32'(digit_sel), 32'h1);
        chk("async_seg", 32'(seg), 32'h3F);
        m = 0; m_pre = 0; m_idx = 0;
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) cycle("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
